// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for EX: 35-cycle shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 multiplier for MUL* ops.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state, w_next;
  logic [2:0]          r_f3;
  logic [XLEN-1:0]     r_a, r_b;
  logic                r_sign;
  logic [5:0]          r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN:0]       r_rem;
  logic                r_busy, r_done;
  logic [XLEN-1:0]     r_result;

  function automatic logic f_a_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction

  function automatic logic f_b_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

  logic            w_accept, w_is_div, w_is_rem, w_sa, w_sb, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special;

  assign w_accept  = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_is_div  = r_f3[2];
  assign w_is_rem  = r_f3[2] & r_f3[1];
  assign w_sa      = f_a_signed(r_f3) & r_a[XLEN-1];
  assign w_sb      = f_b_signed(r_f3) & r_b[XLEN-1];
  assign w_mag_a   = w_sa ? -r_a : r_a;
  assign w_mag_b   = w_sb ? -r_b : r_b;
  assign w_div0    = w_is_div & (r_b == '0);
  assign w_ovf     = w_is_div & ~r_f3[0] & (r_a == MIN_INT) & (r_b == '1);
  assign w_special = w_div0 ? (w_is_rem ? r_a : '1) : (w_is_rem ? '0 : MIN_INT);

  // Multiply step: multiplier sits in the low half and shifts out as the sum shifts in.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_nxt;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: dividend bits shift out of r_quo's top while quotient bits enter below.
  logic [XLEN+1:0] w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  assign w_trial = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = w_trial >= {2'b00, r_b};
  assign w_diff  = w_trial[XLEN:0] - {1'b0, r_b};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_f, w_rem_f, w_fix_res;
  assign w_prod  = r_sign ? -r_acc : r_acc;
  assign w_quo_f = r_sign ? -r_quo : r_quo;
  assign w_rem_f = r_sign ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    case (r_f3)
      3'b000:         w_fix_res = w_prod[XLEN-1:0];
      3'b100, 3'b101: w_fix_res = w_quo_f;
      3'b110, 3'b111: w_fix_res = w_rem_f;
      default:        w_fix_res = w_prod[2*XLEN-1:XLEN];
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fast_p;
  logic [XLEN-1:0]          w_fast_res;
  assign w_fast_p   = $signed({f_a_signed(funct3_i) & op_a_i[XLEN-1], op_a_i})
                    * $signed({f_b_signed(funct3_i) & op_b_i[XLEN-1], op_b_i});
  assign w_fast_res = (funct3_i[1:0] == 2'b00) ? w_fast_p[XLEN-1:0] : w_fast_p[2*XLEN-1:XLEN];
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
        w_next = funct3_i[2] ? S_PREP : S_DONE;
`else
        w_next = S_PREP;
`endif
      end
      S_PREP:  w_next = (w_div0 | w_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == 6'(XLEN-1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_PREP) | (w_next == S_CALC) | (w_next == S_FIX);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_f3 <= funct3_i;
          r_a  <= op_a_i;
          r_b  <= op_b_i;
`ifdef MULDIV_FAST_MUL_EN
          if (!funct3_i[2]) r_result <= w_fast_res;
`endif
        end
        S_PREP: begin
          r_a    <= w_mag_a;
          r_b    <= w_mag_b;
          r_sign <= w_is_rem ? w_sa : (w_sa ^ w_sb);
          r_cnt  <= '0;
          r_acc  <= {{XLEN{1'b0}}, w_mag_b};
          r_quo  <= w_mag_a;
          r_rem  <= '0;
          if (w_next == S_DONE) r_result <= w_special;
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_is_div) begin
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_rem <= w_ge ? w_diff : w_trial[XLEN:0];
          end else begin
            r_acc <= w_acc_nxt;
          end
        end
        S_FIX: if (!flush_i) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign stall_o  = w_accept | r_busy;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M instructions the decoder shares funct3 encodings with (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the ALU in EX. It accepts one operation at a time, holds the pipeline with a stall request while it iterates, and returns one 32-bit result. It owns operand sign conversion, RISC-V corner cases (divide-by-zero, signed overflow), and flush abort.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  EX holds a valid M-extension op; sampled only in IDLE
- funct3_i  in  3  RV32M funct3 (000 MUL … 111 REMU)
- op_a_i  in  XLEN  rs1 value
- op_b_i  in  XLEN  rs2 value
- flush_i  in  1  abort current op (branch/jump redirect)
- stall_o  out  1  pipeline hold request (combinational)
- busy_o  out  1  registered; high in PREP/CALC/FIX
- done_o  out  1  registered; one-cycle result-valid strobe
- result_o  out  XLEN  registered; valid while done_o=1, otherwise holds last value

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if start_i=1 and flush_i=0, latch funct3_i, op_a_i, op_b_i and go to PREP. Otherwise stay.
- PREP takes one cycle.
  - Form magnitudes. MUL/MULH/DIV/REM treat both operands as signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned.
  - Record the result sign. Product sign = sign_a XOR sign_b. Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Clear the 6-bit iteration counter.
  - Divisor = 0: result = 0xFFFFFFFF for DIV/DIVU; result = op_a for REM/REMU. Go straight to DONE.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go straight to DONE.
  - Otherwise go to CALC.
- CALC takes exactly 32 cycles; the counter runs 0..31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient plus 33-bit partial remainder.
  - Counter = 31 → FIX.
- FIX takes one cycle.
  - Two's-complement negate when the recorded sign is 1.
  - MUL selects the low word; MULH* select the high word; DIV* select the quotient; REM* select the remainder.
  - Register result_o, then go to DONE.
- DONE: done_o=1, stall_o=0. start_i is ignored in this state, because the same instruction is still present in EX. Next state is IDLE.
- stall_o = (IDLE & start_i & ~flush_i) | busy_o.
- flush_i=1 in any state: next state IDLE, busy_o=0 and done_o=0 next cycle, result_o unchanged. The latched operation is discarded.

## Timing
- Reset (rst=1 at an edge) sets: state IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, counter=0. Reset mid-operation aborts identically to flush.
- Normal op, with start sampled at edge 0:
  - PREP in cycle 1
  - CALC in cycles 2–33
  - FIX in cycle 34
  - done_o=1 in cycle 35
  - Latency is 35 cycles; stall_o is high for cycles 0–34.
- Special-case op (divide-by-zero, overflow): done_o=1 in cycle 2.
- Back-to-back: the next start is accepted no earlier than the IDLE cycle following DONE. Minimum issue interval is 36 cycles.
- flush_i and start_i in the same IDLE cycle: flush wins, and no op is accepted.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed combinational multiplier.
  - IDLE goes directly to DONE. result_o is registered at the accept edge, and done_o=1 in cycle 1.
  - stall_o is high in cycle 0 only.
  - Divide paths are unchanged.
- MULDIV_FAST_MUL_EN undefined: all multiplies use the iterative 35-cycle path above. No multiplier is inferred.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): result_o=0xFFFFFFEB with done_o in cycle 35; stall_o high cycles 0–34. With MULDIV_FAST_MUL_EN, done_o is in cycle 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, each with done_o in cycle 2. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- flush_i in CALC cycle 10: busy_o=0 and stall_o=0 next cycle, no done_o ever for that op, and result_o keeps its previous value. A new start one cycle later completes normally.
- rst asserted in cycle 20 of an op: all outputs 0 next cycle. start_i held high through DONE: exactly one done_o pulse, and no re-issue.
